flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/lapido_defs.sv | 37 +++
 rtl/flag_stack.sv | 95 +++++++++
 rtl/flag_unit.sv | 112 +++++++++++
 tb/tb_flag_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lapido_defs.sv
// -----------------------------------------------------------------------------
// lapido_defs -- shared architectural definitions for the flag datapath.
//   * FLAG_REG_WIDTH and the bit index of every architectural flag
//   * bit positions inside the flag-stack error vector
//   * stack operation decode type and the jt/jf condition helper
// -----------------------------------------------------------------------------
package lapido_defs;

    localparam int FLAG_REG_WIDTH = 6;

    // Architectural flag bit indices inside the flag register.
    localparam int FLAG_ZERO      = 0;
    localparam int FLAG_CARRY     = 1;
    localparam int FLAG_NEGATIVE  = 2;
    localparam int FLAG_OVERFLOW  = 3;
    localparam int FLAG_PARITY    = 4;
    localparam int FLAG_INTERRUPT = 5;

    // Sticky stack error vector layout.
    localparam int STACK_ERR_W   = 2;
    localparam int STACK_ERR_OVF = 0;
    localparam int STACK_ERR_UNF = 1;

    // Decoded {push, pop} request pair.
    typedef enum logic [1:0] {
        STK_IDLE = 2'b00,
        STK_POP  = 2'b01,
        STK_PUSH = 2'b10,
        STK_BOTH = 2'b11
    } stack_op_e;

    // jt is taken when the flag is set, jf when it is clear.
    function automatic logic cond_result(input logic bit_val, input logic sel_jt);
        return sel_jt ? bit_val : ~bit_val;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// -----------------------------------------------------------------------------
// flag_stack -- LIFO used to save/restore the flag register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, pop       requests; both together is a no-op with no error
//   push_data       value stored on a successful push
//   top_data        entry at the top of the stack (invalid while empty)
//   full, empty     occupancy status
//   err             sticky errors: [STACK_ERR_OVF] overflow, [STACK_ERR_UNF] underflow
// -----------------------------------------------------------------------------
module flag_stack
    import lapido_defs::*;
#(
    parameter int WIDTH = FLAG_REG_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       top_data,
    output logic                   full,
    output logic                   empty,
    output logic [STACK_ERR_W-1:0] err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [CNT_W-1:0]       count_q, count_d;
    logic [STACK_ERR_W-1:0] err_q, err_d;
    logic                   do_write;
    logic [PTR_W-1:0]       wr_ptr, top_ptr;
    stack_op_e              op;

    assign op      = stack_op_e'({push, pop});
    // DEPTH is a power of two, so the low count bits wrap cleanly: a full
    // stack writes nowhere, and its top sits at DEPTH-1.
    assign wr_ptr  = count_q[PTR_W-1:0];
    assign top_ptr = wr_ptr - PTR_W'(1);

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign err      = err_q;
    assign top_data = mem[top_ptr];

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        count_d  = count_q;
        err_d    = err_q;
        do_write = 1'b0;
        case (op)
            STK_PUSH: begin
                if (full) begin
                    err_d[STACK_ERR_OVF] = 1'b1;
                end else begin
                    count_d  = count_q + CNT_W'(1);
                    do_write = 1'b1;
                end
            end
            STK_POP: begin
                if (empty) begin
                    err_d[STACK_ERR_UNF] = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: ;  // idle, or push+pop cancelling each other
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together at the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= '0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only ever
    // read after being written, because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_write && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/flag_unit.sv
// -----------------------------------------------------------------------------
// flag_unit -- architectural flag register with masked writes, save/restore
// stack and a registered jt/jf branch-condition evaluator.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   flags_in, flag_wmask   ALU flag results and per-bit write mask
//   write_enable           applies the masked write
//   eval_valid, flag_code  evaluate the flag selected by flag_code
//   sel_jt_jf              1 = jt (flag set), 0 = jf (flag clear)
//   push, pop              save / restore the flags via flag_stack
//   cond_valid, jt_jf_ok   registered evaluation result (1-cycle latency)
//   flags_out              flag register contents
//   stack_full/empty/err   stack status, err sticky until rst
// -----------------------------------------------------------------------------
module flag_unit
    import lapido_defs::*;
#(
    parameter int FLAG_W      = FLAG_REG_WIDTH,
    parameter int CODE_W      = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLAG_W-1:0]      flags_in,
    input  logic [FLAG_W-1:0]      flag_wmask,
    input  logic                   write_enable,
    input  logic                   eval_valid,
    input  logic [CODE_W-1:0]      flag_code,
    input  logic                   sel_jt_jf,
    input  logic                   push,
    input  logic                   pop,
    output logic                   cond_valid,
    output logic                   jt_jf_ok,
    output logic [FLAG_W-1:0]      flags_out,
    output logic                   stack_full,
    output logic                   stack_empty,
    output logic [STACK_ERR_W-1:0] stack_err
);

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              cond_valid_q, cond_valid_d;
    logic              jt_jf_ok_q, jt_jf_ok_d;
    logic [FLAG_W-1:0] stack_top;
    logic              pop_take;
    logic              sel_bit;

    // The stack stores the post-write value, so a push in the same cycle as a
    // write saves the freshly written flags.
    flag_stack #(
        .WIDTH (FLAG_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (flags_d),
        .top_data  (stack_top),
        .full      (stack_full),
        .empty     (stack_empty),
        .err       (stack_err)
    );

    // A restore only happens when it really pops; a failed or cancelled pop
    // leaves the write path in charge.
    assign pop_take = pop && !push && !stack_empty;

    always_comb begin
        flags_d = flags_q;
        if (pop_take) begin
            flags_d = stack_top;
        end else if (write_enable) begin
            flags_d = (flags_q & ~flag_wmask) | (flags_in & flag_wmask);
        end
    end

    // Evaluation looks at flags_d (bypass) so it sees a same-cycle write or
    // pop. Codes beyond the register width read as a clear flag.
    always_comb begin
        sel_bit = 1'b0;
        for (int i = 0; i < FLAG_W; i++) begin
            if (int'(flag_code) == i) begin
                sel_bit = flags_d[i];
            end
        end
    end

    always_comb begin
        cond_valid_d = eval_valid;
        jt_jf_ok_d   = jt_jf_ok_q;
        if (eval_valid) begin
            jt_jf_ok_d = cond_result(sel_bit, sel_jt_jf);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q      <= '0;
            cond_valid_q <= 1'b0;
            jt_jf_ok_q   <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            cond_valid_q <= cond_valid_d;
            jt_jf_ok_q   <= jt_jf_ok_d;
        end
    end

    assign flags_out  = flags_q;
    assign cond_valid = cond_valid_q;
    assign jt_jf_ok   = jt_jf_ok_q;

endmodule

// File: tb/tb_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_unit -- directed scenarios followed by randomized traffic, every
// cycle compared against a queue-based reference model of the flag unit.
// -----------------------------------------------------------------------------
module tb_flag_unit;

    localparam int FW    = 6;
    localparam int CW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flags_in, flag_wmask;
    logic          write_enable, eval_valid, sel_jt_jf, push, pop;
    logic [CW-1:0] flag_code;
    logic          cond_valid, jt_jf_ok, stack_full, stack_empty;
    logic [FW-1:0] flags_out;
    logic [1:0]    stack_err;

    flag_unit #(.FLAG_W(FW), .CODE_W(CW), .STACK_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flags_in     (flags_in),
        .flag_wmask   (flag_wmask),
        .write_enable (write_enable),
        .eval_valid   (eval_valid),
        .flag_code    (flag_code),
        .sel_jt_jf    (sel_jt_jf),
        .push         (push),
        .pop          (pop),
        .cond_valid   (cond_valid),
        .jt_jf_ok     (jt_jf_ok),
        .flags_out    (flags_out),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [FW-1:0] m_flags;
    logic [FW-1:0] m_stack[$];
    logic [1:0]    m_err;
    logic          m_cv, m_ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output
    // 1 time unit after the rising edge.
    task automatic cycle(input logic r, input logic we, input logic [FW-1:0] fin,
                         input logic [FW-1:0] mask, input logic ev, input logic [CW-1:0] code,
                         input logic sel, input logic pu, input logic po);
        logic [FW-1:0] nf;
        logic          b;
        rst = r; write_enable = we; flags_in = fin; flag_wmask = mask;
        eval_valid = ev; flag_code = code; sel_jt_jf = sel; push = pu; pop = po;
        if (r) begin
            m_flags = '0; m_stack.delete(); m_err = 2'b00; m_cv = 1'b0; m_ok = 1'b0;
        end else begin
            nf = m_flags;
            if (po && !pu && m_stack.size() > 0) nf = m_stack[$];
            else if (we) nf = (m_flags & ~mask) | (fin & mask);
            if (ev) begin
                b    = (code < CW'(FW)) ? nf[code] : 1'b0;
                m_ok = sel ? b : !b;
            end
            m_cv = ev;
            if (pu && !po) begin
                if (m_stack.size() == DEPTH) m_err[0] = 1'b1;
                else m_stack.push_back(nf);
            end else if (po && !pu) begin
                if (m_stack.size() == 0) m_err[1] = 1'b1;
                else void'(m_stack.pop_back());
            end
            m_flags = nf;
        end
        @(posedge clk);
        #1;
        check("flags_out",   32'(flags_out),   32'(m_flags));
        check("cond_valid",  32'(cond_valid),  32'(m_cv));
        check("jt_jf_ok",    32'(jt_jf_ok),    32'(m_ok));
        check("stack_full",  32'(stack_full),  32'(m_stack.size() == DEPTH));
        check("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
        check("stack_err",   32'(stack_err),   32'(m_err));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset and its documented state.
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("rst_empty", 32'(stack_empty), 32'd1);
        check("rst_err",   32'(stack_err),   32'd0);

        // Full write of 000101 with same-cycle jt on flag 2.
        cycle(1'b0, 1'b1, 6'b000101, 6'b111111, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        check("wr_full",  32'(flags_out), 32'h05);
        check("eval_byp", 32'(jt_jf_ok),  32'd1);
        idle();
        check("ok_hold",  32'(jt_jf_ok),  32'd1);

        // Partial mask clears the two low bits; jf on flag 0 is taken.
        cycle(1'b0, 1'b1, 6'b111111, 6'b111111, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 6'b000000, 6'b000011, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("wr_mask", 32'(flags_out), 32'h3C);
        check("jf_bit0", 32'(jt_jf_ok),  32'd1);

        // Out-of-range flag code reads as clear.
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        check("jt_oor", 32'(jt_jf_ok), 32'd0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        check("jf_oor", 32'(jt_jf_ok), 32'd1);

        // Push five distinct values into a four-deep stack.
        for (int v = 1; v <= 5; v++)
            cycle(1'b0, 1'b1, 6'(v), 6'b111111, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("ovf_full", 32'(stack_full), 32'd1);
        check("ovf_err",  32'(stack_err),  32'b01);
        for (int v = 4; v >= 1; v--) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            check("lifo_pop", 32'(flags_out), 32'(v));
        end
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("unf_err",   32'(stack_err), 32'b11);
        check("unf_flags", 32'(flags_out), 32'h01);

        // Pop beats a same-cycle write; eval sees the popped value.
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 6'b100100, 6'b111111, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 6'b011011, 6'b111111, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 6'b000000, 6'b111111, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        check("pop_wins", 32'(flags_out), 32'h24);
        check("pop_eval", 32'(jt_jf_ok),  32'd1);
        // Push and pop together leave the stack alone and follow the write.
        cycle(1'b0, 1'b1, 6'b000111, 6'b111111, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 6'b110000, 6'b111111, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("pp_flags", 32'(flags_out),   32'h30);
        check("pp_empty", 32'(stack_empty), 32'd0);

        // Reset discards a concurrent eval and write.
        cycle(1'b1, 1'b1, 6'b111111, 6'b111111, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
        check("rst_cv",    32'(cond_valid), 32'd0);
        check("rst_flags", 32'(flags_out),  32'd0);

        // Randomized traffic; pushes slightly favoured so the stack fills.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 1)),
                  6'($urandom), 6'($urandom),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 8)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
